// File: rtl/instr_mem_loader.sv
// Instruction memory: 1-cycle synchronous fetch port plus a byte-serial program loader.
// Define INSTR_MEM_READBACK_EN to add the combinational debug readback port.
module instr_mem_loader #(
  parameter int               NBITS       = 32,
  parameter int               DEPTH_WORDS = 256,
  parameter logic [NBITS-1:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int               AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NBITS-1:0] i_PC,
  input  logic             i_rd_en,
  output logic [NBITS-1:0] o_instr,
  output logic             o_instr_valid,
  output logic             o_misaligned,
  input  logic             i_load_start,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_load_busy,
  output logic             o_load_done,
  output logic [AW:0]      o_word_count,
  output logic             o_overflow
`ifdef INSTR_MEM_READBACK_EN
  ,
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [NBITS-1:0] o_dbg_word
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_byte_cnt;
  logic [AW-1:0]    r_ptr;
  logic [NBITS-9:0] r_buf;
  logic [AW:0]      r_word_count;
  logic             r_busy, r_done, r_overflow, r_full;
  logic [NBITS-1:0] r_instr;
  logic             r_instr_valid, r_misaligned;
  logic [NBITS-1:0] r_mem [DEPTH_WORDS];

  logic             w_byte_in, w_word_done, w_last, w_ptr_last;
  logic [NBITS-1:0] w_word;
  logic             w_unused_pc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte_in   = (r_state == S_LOAD) && i_byte_valid && !i_load_start;
    w_word      = {r_buf, i_byte};
    w_ptr_last  = (r_ptr == LAST_IDX);
    w_word_done = w_byte_in && (r_byte_cnt == 2'd3);
    w_last      = w_word_done && ((w_word == HALT_WORD) || w_ptr_last);
    case (r_state)
      S_IDLE:  if (i_load_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (i_load_start) w_state_nxt = S_LOAD;
               else if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (i_load_start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_byte_cnt   <= '0;
      r_ptr        <= '0;
      r_buf        <= '0;
      r_word_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_full       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_LOAD);
      if (i_load_start) begin
        r_byte_cnt   <= '0;
        r_ptr        <= '0;
        r_word_count <= '0;
        r_done       <= 1'b0;
        r_overflow   <= 1'b0;
        r_full       <= 1'b0;
      end else if (w_byte_in) begin
        if (w_word_done) begin
          r_byte_cnt   <= '0;
          r_ptr        <= r_ptr + 1'b1;
          r_word_count <= r_word_count + 1'b1;
          if (w_last) begin
            r_done <= 1'b1;
            r_full <= w_ptr_last;
          end
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
          r_buf      <= {r_buf[NBITS-17:0], i_byte};
        end
      end else if ((r_state != S_LOAD) && r_full && i_byte_valid) begin
        // memory was filled to the last index; further bytes have nowhere to go
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_word_done) r_mem[r_ptr] <= w_word;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_misaligned  <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else if (i_rd_en) begin
      r_instr       <= r_mem[i_PC[AW+1:2]];
      r_instr_valid <= 1'b1;
      r_misaligned  <= |i_PC[1:0];
    end
  end

  assign w_unused_pc   = ^i_PC[NBITS-1:AW+2];
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_misaligned  = r_misaligned;
  assign o_load_busy   = r_busy;
  assign o_load_done   = r_done;
  assign o_word_count  = r_word_count;
  assign o_overflow    = r_overflow;

`ifdef INSTR_MEM_READBACK_EN
  assign o_dbg_word = r_mem[i_dbg_addr];
`else
  // readback port not present in this build
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: 256-word instance for load/fetch/reset,
// 4-word instance for the full-memory and overflow behaviour.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc, pc4;
  logic        rd, rd4, ls, ls4, bv, bv4;
  logic [7:0]  bt, bt4;
  logic [31:0] instr, instr4;
  logic        ival, ival4, mis, mis4, busy, busy4, done, done4, ovf, ovf4;
  logic [8:0]  wcnt;
  logic [2:0]  wcnt4;
`ifdef INSTR_MEM_READBACK_EN
  logic [7:0]  dbg_a;
  logic [1:0]  dbg_a4;
  logic [31:0] dbg_w, dbg_w4;
`endif

  instr_mem_loader dut (
    .i_clk(clk), .i_reset(rst), .i_PC(pc), .i_rd_en(rd),
    .o_instr(instr), .o_instr_valid(ival), .o_misaligned(mis),
    .i_load_start(ls), .i_byte(bt), .i_byte_valid(bv),
    .o_load_busy(busy), .o_load_done(done), .o_word_count(wcnt), .o_overflow(ovf)
`ifdef INSTR_MEM_READBACK_EN
    , .i_dbg_addr(dbg_a), .o_dbg_word(dbg_w)
`endif
  );

  instr_mem_loader #(.DEPTH_WORDS(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_PC(pc4), .i_rd_en(rd4),
    .o_instr(instr4), .o_instr_valid(ival4), .o_misaligned(mis4),
    .i_load_start(ls4), .i_byte(bt4), .i_byte_valid(bv4),
    .o_load_busy(busy4), .o_load_done(done4), .o_word_count(wcnt4), .o_overflow(ovf4)
`ifdef INSTR_MEM_READBACK_EN
    , .i_dbg_addr(dbg_a4), .o_dbg_word(dbg_w4)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_mem  [256];
  logic [31:0] exp_mem4 [4];
  int          exp_ptr, exp_ptr4;
  logic [32:0] sb_q [$];
  logic [31:0] last_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input bit d4);
    if (d4) begin ls4 = 1'b1; exp_ptr4 = 0; end
    else    begin ls  = 1'b1; exp_ptr  = 0; end
    step();
    ls = 1'b0; ls4 = 1'b0;
  endtask

  task automatic send_byte(input bit d4, input logic [7:0] b);
    if (d4) begin bt4 = b; bv4 = 1'b1; end
    else    begin bt  = b; bv  = 1'b1; end
    step();
    bv = 1'b0; bv4 = 1'b0;
  endtask

  task automatic send_word(input bit d4, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(d4, w[i*8 +: 8]);
    if (d4) begin exp_mem4[exp_ptr4] = w; exp_ptr4++; end
    else    begin exp_mem[exp_ptr]   = w; exp_ptr++;  end
  endtask

  // expected {misaligned, word} is queued at drive time and checked on the output cycle
  task automatic fetch(input bit d4, input logic [31:0] a, input string tag);
    logic [32:0] e;
    if (d4) begin pc4 = a; rd4 = 1'b1; sb_q.push_back({a[1:0] != 2'b00, exp_mem4[a[3:2]]}); end
    else    begin pc  = a; rd  = 1'b1; sb_q.push_back({a[1:0] != 2'b00, exp_mem[a[9:2]]}); end
    step();
    rd = 1'b0; rd4 = 1'b0;
    e = sb_q.pop_front();
    if (d4) begin
      chk({tag, "_instr"}, instr4, e[31:0]);
      chk({tag, "_mis"},   {31'd0, mis4}, {31'd0, e[32]});
      chk({tag, "_valid"}, {31'd0, ival4}, 32'd1);
    end else begin
      chk({tag, "_instr"}, instr, e[31:0]);
      chk({tag, "_mis"},   {31'd0, mis}, {31'd0, e[32]});
      chk({tag, "_valid"}, {31'd0, ival}, 32'd1);
      last_instr = e[31:0];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pc = '0; pc4 = '0; rd = 1'b0; rd4 = 1'b0;
    ls = 1'b0; ls4 = 1'b0; bt = '0; bt4 = '0; bv = 1'b0; bv4 = 1'b0;
`ifdef INSTR_MEM_READBACK_EN
    dbg_a = '0; dbg_a4 = '0;
`endif
    #2;
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, ival}, 32'd0);
    chk("rst_mis",   {31'd0, mis},  32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_wcnt",  {23'd0, wcnt}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf},  32'd0);
    #1 rst = 1'b0;
    step();

    // happy path load
    start_load(1'b0);
    chk("ld_busy", {31'd0, busy}, 32'd1);
    chk("ld_done0", {31'd0, done}, 32'd0);
    send_word(1'b0, 32'h2008_0005);
    chk("ld_wcnt1", {23'd0, wcnt}, 32'd1);
    send_word(1'b0, 32'h2009_0007);
    send_word(1'b0, 32'hFFFF_FFFF);
    chk("ld_wcnt", {23'd0, wcnt}, 32'd3);
    chk("ld_done", {31'd0, done}, 32'd1);
    chk("ld_busy_end", {31'd0, busy}, 32'd0);

    fetch(1'b0, 32'd0, "f0");
    fetch(1'b0, 32'd4, "f4");
    fetch(1'b0, 32'd8, "f8");

    // stall: output holds while PC moves
    fetch(1'b0, 32'd4, "f4b");
    for (int i = 0; i < 3; i++) begin
      pc = 32'd8 + 32'(i) * 4;
      step();
      chk("stall_instr", instr, last_instr);
      chk("stall_valid", {31'd0, ival}, 32'd1);
    end
    fetch(1'b0, 32'd6, "mis6");
    fetch(1'b0, 32'h0000_0404, "wrap");
    fetch(1'b0, 32'd0, "f0b");

    // restart mid-load; byte sampled with i_load_start is dropped
    rd = 1'b1; pc = 32'd0;
    start_load(1'b0);
    step();
    chk("blk_instr", instr, 32'd0);
    chk("blk_valid", {31'd0, ival}, 32'd0);
    rd = 1'b0;
    send_byte(1'b0, 8'h55);
    send_byte(1'b0, 8'h66);
    bt = 8'h77; bv = 1'b1;
    start_load(1'b0);
    bv = 1'b0;
    chk("rs_wcnt", {23'd0, wcnt}, 32'd0);
    send_word(1'b0, 32'h1122_3344);
    send_word(1'b0, 32'hFFFF_FFFF);
    chk("rs_wcnt2", {23'd0, wcnt}, 32'd2);
    chk("rs_done",  {31'd0, done}, 32'd1);
    fetch(1'b0, 32'd0, "rs0");
    fetch(1'b0, 32'd4, "rs4");
    fetch(1'b0, 32'd8, "rs8");
    send_byte(1'b0, 8'h12);
    chk("dn_ign_wcnt", {23'd0, wcnt}, 32'd2);
    chk("dn_ign_ovf",  {31'd0, ovf},  32'd0);

    // async reset mid-load
    start_load(1'b0);
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'hA1 + 8'(i));
    exp_mem[0] = 32'hA1A2_A3A4;
    send_byte(1'b0, 8'hB1);
    send_byte(1'b0, 8'hB2);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_wcnt", {23'd0, wcnt}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_instr", instr, 32'd0);
    chk("ar_valid", {31'd0, ival}, 32'd0);
    #1 rst = 1'b0;
    step();
    fetch(1'b0, 32'd0, "ar0");
    fetch(1'b0, 32'd4, "ar4");
    start_load(1'b0);
    send_word(1'b0, 32'hC0C1_C2C3);
    send_word(1'b0, 32'hFFFF_FFFF);
    chk("ar_rl_wcnt", {23'd0, wcnt}, 32'd2);
    fetch(1'b0, 32'd0, "arl0");

    // full-memory termination and overflow on the 4-word instance
    start_load(1'b1);
    for (int k = 0; k < 4; k++) begin
      send_word(1'b1, 32'h0102_0304 + 32'(k) * 32'h1010_1010);
      if (k == 2) begin
        chk("ov_wcnt3", {29'd0, wcnt4}, 32'd3);
        chk("ov_done3", {31'd0, done4}, 32'd0);
      end
    end
    chk("ov_done", {31'd0, done4}, 32'd1);
    chk("ov_busy", {31'd0, busy4}, 32'd0);
    chk("ov_wcnt", {29'd0, wcnt4}, 32'd4);
    chk("ov_pre",  {31'd0, ovf4},  32'd0);
    send_byte(1'b1, 8'h5A);
    chk("ov_set",  {31'd0, ovf4},  32'd1);
    chk("ov_wcnt_hold", {29'd0, wcnt4}, 32'd4);
    for (int k = 0; k < 5; k++) fetch(1'b1, 32'(k) * 4, "ov_mem");
    start_load(1'b1);
    chk("ov_clr",  {31'd0, ovf4},  32'd0);
    chk("ov_done_clr", {31'd0, done4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
